// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss handler: fetches one line from memory, installs it in the LRU victim way, then pulses refill_done.
// Latency: miss cycle to refill_done is 4+line_words cycles (inclusive), plus request-wait and beat-gap cycles.
// Backpressure: mem_rd_req is held until mem_rd_ready, beats are accepted whenever mem_rd_valid is high, and stall holds fetch for the whole refill.
module icache_refill_ctrl #(
    parameter int addr_width = 4,
    parameter int tag_width  = 25,
    parameter int way        = 2,
    parameter int line_words = 2
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        lookup_valid,
    input  logic [addr_width-1:0]       lookup_index,
    input  logic [tag_width-1:0]        lookup_tag,
    input  logic [way-1:0]              hit,
    output logic                        stall,
    output logic                        refill_done,
    output logic                        mem_rd_req,
    output logic [31:0]                 mem_rd_addr,
    input  logic                        mem_rd_ready,
    input  logic                        mem_rd_valid,
    input  logic [31:0]                 mem_rd_data,
    output logic [way-1:0]              TagV_we,
    output logic [addr_width-1:0]       TagV_addr_write,
    output logic [tag_width:0]          TagV_din_write,
    output logic [way-1:0]              data_we,
    output logic [addr_width-1:0]       data_waddr,
    output logic [32*line_words-1:0]    data_wdata
);

    localparam int OFF_W  = 32 - tag_width - addr_width;
    localparam int BEAT_W = (line_words > 1) ? $clog2(line_words) : 1;
    localparam int SETS   = 1 << addr_width;

    typedef enum logic [2:0] {IDLE, REQ, RECV, WRITE, DONE} state_t;

    state_t                         r_state;
    state_t                         w_next;
    logic [addr_width-1:0]          r_index;
    logic [tag_width-1:0]           r_tag;
    logic                           r_victim;
    logic [BEAT_W-1:0]              r_beat_cnt;
    logic [SETS-1:0]                r_lru;
    logic [line_words-1:0][31:0]    r_line;

    logic                           w_miss;
    logic                           w_last_beat;
    logic [way-1:0]                 w_victim_oh;

    assign w_miss      = lookup_valid && (hit == '0);
    assign w_last_beat = mem_rd_valid && (r_beat_cnt == BEAT_W'(line_words - 1));
    assign w_victim_oh = way'(1) << r_victim;

    assign mem_rd_addr     = {r_tag, r_index, {OFF_W{1'b0}}};
    assign TagV_addr_write = r_index;
    assign data_waddr      = r_index;
    assign TagV_din_write  = {1'b1, r_tag};
    assign data_wdata      = r_line;

    always_comb begin
        w_next      = r_state;
        stall       = 1'b0;
        refill_done = 1'b0;
        mem_rd_req  = 1'b0;
        TagV_we     = '0;
        data_we     = '0;
        case (r_state)
            IDLE: begin
                // Gated by rstn so a miss presented during reset cannot raise stall.
                stall = rstn && w_miss;
                if (w_miss) w_next = REQ;
            end
            REQ: begin
                stall      = 1'b1;
                mem_rd_req = 1'b1;
                if (mem_rd_ready) w_next = RECV;
            end
            RECV: begin
                stall = 1'b1;
                if (w_last_beat) w_next = WRITE;
            end
            WRITE: begin
                stall   = 1'b1;
                TagV_we = w_victim_oh;
                data_we = w_victim_oh;
                w_next  = DONE;
            end
            DONE: begin
                refill_done = 1'b1;
                w_next      = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_index    <= '0;
            r_tag      <= '0;
            r_victim   <= 1'b0;
            r_beat_cnt <= '0;
            r_lru      <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    // Double hit resolves to way 0, so way 1 becomes the next victim.
                    if (lookup_valid) begin
                        if (hit[0]) begin
                            r_lru[lookup_index] <= 1'b1;
                        end else if (hit[1]) begin
                            r_lru[lookup_index] <= 1'b0;
                        end else begin
                            r_index    <= lookup_index;
                            r_tag      <= lookup_tag;
                            r_victim   <= r_lru[lookup_index];
                            r_beat_cnt <= '0;
                        end
                    end
                end
                RECV: begin
                    if (mem_rd_valid) r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + 1'b1;
                end
                WRITE: r_lru[r_index] <= ~r_victim;
                default: ;
            endcase
        end
    end

    // Data-only buffer: the state reset alone keeps a partial line from ever being written.
    always_ff @(posedge clk) begin
        if (r_state == RECV && mem_rd_valid) r_line[r_beat_cnt] <= mem_rd_data;
    end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Randomized bench for icache_refill_ctrl: a driver issues hits and misses while acting as memory,
// and a negedge monitor pops expected requests, writes and done-pulse cycles from scoreboard queues.
module tb_icache_refill_ctrl;
    localparam int AW = 4, TW = 25, WAY = 2, LW = 2, OFFW = 32 - TW - AW;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              lookup_valid, mem_rd_ready, mem_rd_valid;
    logic [AW-1:0]     lookup_index;
    logic [TW-1:0]     lookup_tag;
    logic [WAY-1:0]    hit;
    logic [31:0]       mem_rd_data;
    logic              stall, refill_done, mem_rd_req;
    logic [31:0]       mem_rd_addr;
    logic [WAY-1:0]    TagV_we, data_we;
    logic [AW-1:0]     TagV_addr_write, data_waddr;
    logic [TW:0]       TagV_din_write;
    logic [32*LW-1:0]  data_wdata;

    icache_refill_ctrl #(.addr_width(AW), .tag_width(TW), .way(WAY), .line_words(LW)) dut (
        .clk(clk), .rstn(rstn), .lookup_valid(lookup_valid), .lookup_index(lookup_index),
        .lookup_tag(lookup_tag), .hit(hit), .stall(stall), .refill_done(refill_done),
        .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_ready(mem_rd_ready),
        .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data), .TagV_we(TagV_we),
        .TagV_addr_write(TagV_addr_write), .TagV_din_write(TagV_din_write), .data_we(data_we),
        .data_waddr(data_waddr), .data_wdata(data_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WAY-1:0]   we;
        logic [AW-1:0]    idx;
        logic [TW:0]      din;
        logic [32*LW-1:0] data;
    } wr_t;

    wr_t         exp_wr_q[$];
    logic [31:0] exp_req_q[$];
    int          exp_done_q[$];
    bit          lru_m[1<<AW];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    wr_t         mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rstn) begin
            if (mem_rd_req) begin
                chk("req_expected", 64'(exp_req_q.size() != 0), 64'd1);
                if (mem_rd_ready && exp_req_q.size() != 0)
                    chk("mem_rd_addr", 64'(mem_rd_addr), 64'(exp_req_q.pop_front()));
            end
            if (TagV_we != '0 || data_we != '0) begin
                chk("write_expected", 64'(exp_wr_q.size() != 0), 64'd1);
                if (exp_wr_q.size() != 0) begin
                    mon_e = exp_wr_q.pop_front();
                    chk("TagV_we", 64'(TagV_we), 64'(mon_e.we));
                    chk("data_we", 64'(data_we), 64'(mon_e.we));
                    chk("TagV_addr_write", 64'(TagV_addr_write), 64'(mon_e.idx));
                    chk("data_waddr", 64'(data_waddr), 64'(mon_e.idx));
                    chk("TagV_din_write", 64'(TagV_din_write), 64'(mon_e.din));
                    chk("data_wdata", 64'(data_wdata), 64'(mon_e.data));
                end
            end
            if (refill_done) begin
                chk("done_expected", 64'(exp_done_q.size() != 0), 64'd1);
                if (exp_done_q.size() != 0) chk("done_cycle", 64'(cyc), 64'(exp_done_q.pop_front()));
                chk("done_stall", 64'(stall), 64'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic noise(input bit en);
        lookup_valid = en ? 1'($urandom_range(1, 0)) : 1'b0;
        hit          = 2'($urandom);
        lookup_index = AW'($urandom);
        lookup_tag   = TW'($urandom);
    endtask

    task automatic do_hit(input logic [AW-1:0] idx, input logic [1:0] h);
        lookup_valid = 1'b1; hit = h; lookup_index = idx; lookup_tag = TW'($urandom);
        lru_m[idx] = h[0] ? 1'b1 : 1'b0;
        @(negedge clk);
        chk("hit_stall", 64'(stall), 64'd0);
        tick();
        lookup_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            lookup_valid = 1'b0; mem_rd_valid = 1'b0;
            @(negedge clk);
            chk("idle_stall", 64'(stall), 64'd0);
            chk("idle_req", 64'(mem_rd_req), 64'd0);
            tick();
        end
    endtask

    task automatic stray();
        lookup_valid = 1'b0; mem_rd_valid = 1'b1; mem_rd_data = $urandom;
        @(negedge clk);
        chk("stray_stall", 64'(stall), 64'd0);
        chk("stray_req", 64'(mem_rd_req), 64'd0);
        tick();
        mem_rd_valid = 1'b0;
    endtask

    // One complete refill: miss, w ready-low cycles, LW beats with random gaps, WRITE, DONE.
    task automatic do_miss(input logic [AW-1:0] idx, input logic [TW-1:0] tag, input int w,
                           input int max_gap, input bit nz, input bit fixed);
        int          gaps[LW];
        int          g_total;
        int          k;
        logic [31:0] words[LW];
        logic [31:0] addr;
        wr_t         e;
        bit          victim;
        g_total = 0;
        for (int j = 0; j < LW; j++) begin
            gaps[j]  = $urandom_range(max_gap, 0);
            g_total += gaps[j];
            words[j] = fixed ? 32'h11111111 * (j + 1) : $urandom;
            e.data[j*32 +: 32] = words[j];
        end
        victim = lru_m[idx];
        addr   = (32'(tag) << (AW + OFFW)) | (32'(idx) << OFFW);
        e.we   = victim ? 2'b10 : 2'b01;
        e.idx  = idx;
        e.din  = {1'b1, tag};
        lru_m[idx] = !victim;
        k = cyc;
        exp_req_q.push_back(addr);
        exp_wr_q.push_back(e);
        exp_done_q.push_back(k + 3 + LW + w + g_total);

        lookup_valid = 1'b1; hit = '0; lookup_index = idx; lookup_tag = tag; mem_rd_ready = 1'b0;
        @(negedge clk);
        chk("miss_stall", 64'(stall), 64'd1);
        tick();
        for (int i = 0; i < w; i++) begin
            noise(nz); mem_rd_ready = 1'b0;
            @(negedge clk);
            chk("wait_stall", 64'(stall), 64'd1);
            chk("wait_req", 64'(mem_rd_req), 64'd1);
            chk("wait_addr", 64'(mem_rd_addr), 64'(addr));
            tick();
        end
        noise(nz); mem_rd_ready = 1'b1;
        @(negedge clk);
        chk("accept_req", 64'(mem_rd_req), 64'd1);
        tick();
        mem_rd_ready = 1'b0;
        for (int j = 0; j < LW; j++) begin
            for (int g = 0; g < gaps[j]; g++) begin
                noise(nz); mem_rd_valid = 1'b0;
                @(negedge clk);
                chk("gap_stall", 64'(stall), 64'd1);
                tick();
            end
            noise(nz); mem_rd_valid = 1'b1; mem_rd_data = words[j];
            @(negedge clk);
            chk("beat_stall", 64'(stall), 64'd1);
            tick();
        end
        mem_rd_valid = 1'b0;
        noise(nz);
        @(negedge clk);
        chk("write_stall", 64'(stall), 64'd1);
        tick();
        noise(nz);
        @(negedge clk);
        tick();
        lookup_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        lookup_valid = 1'b1; hit = '0; lookup_index = '0; lookup_tag = '0;
        mem_rd_ready = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = '0;
        for (int i = 0; i < (1 << AW); i++) lru_m[i] = 1'b0;
        #12;
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_req", 64'(mem_rd_req), 64'd0);
        chk("rst_tagv_we", 64'(TagV_we), 64'd0);
        chk("rst_data_we", 64'(data_we), 64'd0);
        chk("rst_done", 64'(refill_done), 64'd0);
        tick();
        lookup_valid = 1'b0; rstn = 1'b1;
        idle(2);

        // Basic refill: index 3, back-to-back beats, victim way 0.
        do_miss(4'd3, 25'h0ABCDEF, 0, 0, 1'b0, 1'b1);
        idle(1);
        // Hit way 0 makes way 1 the victim; the refill then flips it back to way 0.
        do_hit(4'd5, 2'b01);
        do_miss(4'd5, TW'($urandom), 0, 1, 1'b1, 1'b0);
        do_miss(4'd5, TW'($urandom), 0, 1, 1'b1, 1'b0);
        // Long request stall with lookups arriving throughout.
        do_miss(4'd7, TW'($urandom), 10, 0, 1'b1, 1'b0);
        // Double hit counts as way 0; single way-1 hit points victim back at way 0.
        do_hit(4'd2, 2'b11);
        do_miss(4'd2, TW'($urandom), 1, 2, 1'b0, 1'b0);
        do_hit(4'd2, 2'b10);
        do_miss(4'd2, TW'($urandom), 0, 0, 1'b0, 1'b0);
        // Stray return beat in IDLE must not disturb the next refill.
        stray();
        idle(1);
        do_miss(4'd9, TW'($urandom), 0, 0, 1'b0, 1'b0);

        // Reset after the first beat of a refill.
        exp_req_q.push_back((32'(25'h1234567) << (AW + OFFW)) | (32'(4) << OFFW));
        lookup_valid = 1'b1; hit = '0; lookup_index = 4'd4; lookup_tag = 25'h1234567;
        @(negedge clk);
        tick();
        lookup_valid = 1'b0; mem_rd_ready = 1'b1;
        @(negedge clk);
        tick();
        mem_rd_ready = 1'b0; mem_rd_valid = 1'b1; mem_rd_data = 32'hDEADBEEF;
        @(negedge clk);
        chk("abort_beat_stall", 64'(stall), 64'd1);
        tick();
        mem_rd_valid = 1'b0; lookup_valid = 1'b1; hit = '0;
        #2 rstn = 1'b0;
        #1;
        chk("abort_stall", 64'(stall), 64'd0);
        chk("abort_req", 64'(mem_rd_req), 64'd0);
        chk("abort_tagv_we", 64'(TagV_we), 64'd0);
        chk("abort_data_we", 64'(data_we), 64'd0);
        chk("abort_done", 64'(refill_done), 64'd0);
        for (int i = 0; i < (1 << AW); i++) lru_m[i] = 1'b0;
        tick();
        tick();
        rstn = 1'b1; lookup_valid = 1'b0;
        idle(2);
        do_miss(4'd4, TW'($urandom), 0, 1, 1'b0, 1'b0);

        // Random mix of hits and misses on a few sets so LRU state interacts.
        for (int n = 0; n < 40; n++) begin
            logic [AW-1:0] idx;
            idx = AW'($urandom_range(3, 0));
            case ($urandom_range(3, 0))
                0: do_hit(idx, 2'b01);
                1: do_hit(idx, 2'b10);
                2: do_hit(idx, 2'b11);
                default: do_miss(idx, TW'($urandom), $urandom_range(3, 0), 2, 1'($urandom), 1'b0);
            endcase
            if ($urandom_range(3, 0) == 0) stray();
        end

        idle(3);
        chk("req_queue_empty", 64'(exp_req_q.size()), 64'd0);
        chk("write_queue_empty", 64'(exp_wr_q.size()), 64'd0);
        chk("done_queue_empty", 64'(exp_done_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
